// File: rtl/pair_distance_generator_pkg.sv
// Shared types for the pair distance generator and the systolic sorter it feeds.
// The sorter imports the same id_pair_s, so its layout must not change.
package pair_distance_generator_pkg;

  localparam int INDEX_WIDTH = 32;
  localparam int COORD_W     = 17;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] id1;
    logic [INDEX_WIDTH-1:0] id2;
  } id_pair_s;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } point_s;

  function automatic coord_t absDiff(input coord_t a, input coord_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/pair_distance_generator_if.sv
// Point-load and pair-output handshakes of the pair distance generator.
// The master modport is the generator side; slave is the feeder/sorter side.
interface pair_distance_generator_if
  import pair_distance_generator_pkg::*;
#(
  parameter int COORD_WIDTH = 17,
  parameter int DIST_WIDTH  = 64
);

  logic                   pt_valid;
  logic                   pt_ready;
  logic [COORD_WIDTH-1:0] pt_x;
  logic [COORD_WIDTH-1:0] pt_y;
  logic [COORD_WIDTH-1:0] pt_z;
  logic                   pt_last;

  logic                   out_valid;
  logic                   out_ready;
  logic [DIST_WIDTH-1:0]  out_data;
  id_pair_s               out_metadata;
  logic                   out_last;

  modport master (
    input  pt_valid, pt_x, pt_y, pt_z, pt_last, out_ready,
    output pt_ready, out_valid, out_data, out_metadata, out_last
  );

  modport slave (
    output pt_valid, pt_x, pt_y, pt_z, pt_last, out_ready,
    input  pt_ready, out_valid, out_data, out_metadata, out_last
  );

endinterface

// File: rtl/pair_distance_generator_sq_dist3.sv
// Two-stage squared Euclidean distance between two 3-D points, held when en_i is low.
// Sums wider than DIST_WIDTH saturate to all-ones.
module sq_dist3
  import pair_distance_generator_pkg::*;
#(
  parameter int DIST_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  point_s                a_i,
  input  point_s                b_i,
  output logic [DIST_WIDTH-1:0] dist_o
);

  localparam int CW    = $bits(coord_t);
  localparam int SUM_W = 2 * CW + 2;

  coord_t                dx_q, dy_q, dz_q;
  logic [SUM_W-1:0]      sum;
  logic [DIST_WIDTH-1:0] dist_d, dist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q   <= '0;
      dy_q   <= '0;
      dz_q   <= '0;
      dist_q <= '0;
    end else if (en_i) begin
      dx_q   <= absDiff(a_i.x, b_i.x);
      dy_q   <= absDiff(a_i.y, b_i.y);
      dz_q   <= absDiff(a_i.z, b_i.z);
      dist_q <= dist_d;
    end
  end

  assign sum = SUM_W'(dx_q) * SUM_W'(dx_q)
             + SUM_W'(dy_q) * SUM_W'(dy_q)
             + SUM_W'(dz_q) * SUM_W'(dz_q);

  generate
    if (DIST_WIDTH >= SUM_W) begin : g_wide
      assign dist_d = DIST_WIDTH'(sum);
    end else begin : g_sat
      assign dist_d = (|sum[SUM_W-1:DIST_WIDTH]) ? '1 : sum[DIST_WIDTH-1:0];
    end
  endgenerate

  assign dist_o = dist_q;

endmodule

// File: rtl/pair_distance_generator.sv
// Loads a set of 3-D points, then streams every pair (i<j) with its squared distance
// through a 3-stage pipeline toward the systolic sorter.
module pair_distance_generator
  import pair_distance_generator_pkg::*;
#(
  parameter int MAX_POINTS  = 1024,
  parameter int COORD_WIDTH = 17,
  parameter int DIST_WIDTH  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  pair_distance_generator_if.master   bus,
  output logic                        busy_o,
  output logic                        err_overflow_o,
  output logic                        err_too_few_o
);

  localparam int CNT_W  = $clog2(MAX_POINTS + 1);
  localparam int ADDR_W = $clog2(MAX_POINTS);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_GEN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] nPoints_q, nPoints_d;
  logic [CNT_W-1:0] iIdx_q, iIdx_d, jIdx_q, jIdx_d;
  logic             errOverflow_q, errOverflow_d;
  logic             errTooFew_q, errTooFew_d;

  point_s           memA [MAX_POINTS];
  point_s           memB [MAX_POINTS];
  point_s           ptIn, rdA_q, rdB_q;

  logic             v1_q, v2_q, v3_q;
  logic             last1_q, last2_q, last3_q;
  id_pair_s         ids1_q, ids2_q, ids3_q;

  logic             en, ptAccept, ptStore, issue, lastPair;

  assign en       = !v3_q || bus.out_ready;
  assign ptAccept = bus.pt_valid && (state_q == ST_LOAD);
  assign ptStore  = ptAccept && (nPoints_q < CNT_W'(MAX_POINTS));
  assign issue    = (state_q == ST_GEN) && en;
  assign lastPair = (iIdx_q == nPoints_q - CNT_W'(2)) && (jIdx_q == nPoints_q - CNT_W'(1));
  assign ptIn     = '{x: coord_t'(bus.pt_x), y: coord_t'(bus.pt_y), z: coord_t'(bus.pt_z)};

  always_comb begin
    state_d       = state_q;
    nPoints_d     = nPoints_q;
    iIdx_d        = iIdx_q;
    jIdx_d        = jIdx_q;
    errOverflow_d = errOverflow_q;
    errTooFew_d   = errTooFew_q;
    case (state_q)
      ST_LOAD: begin
        if (ptStore) nPoints_d = nPoints_q + CNT_W'(1);
        if (ptAccept && !ptStore) errOverflow_d = 1'b1;
        if (ptAccept && bus.pt_last) begin
          if (nPoints_d < CNT_W'(2)) begin
            errTooFew_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_GEN;
            iIdx_d  = '0;
            jIdx_d  = CNT_W'(1);
          end
        end
      end
      ST_GEN: begin
        // Row change jumps straight to (i+1, i+2) so no issue slot is lost.
        if (issue) begin
          if (lastPair) begin
            state_d = ST_DRAIN;
          end else if (jIdx_q == nPoints_q - CNT_W'(1)) begin
            iIdx_d = iIdx_q + CNT_W'(1);
            jIdx_d = iIdx_q + CNT_W'(2);
          end else begin
            jIdx_d = jIdx_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!v1_q && !v2_q && (!v3_q || bus.out_ready)) state_d = ST_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      nPoints_q     <= '0;
      iIdx_q        <= '0;
      jIdx_q        <= '0;
      errOverflow_q <= 1'b0;
      errTooFew_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      nPoints_q     <= nPoints_d;
      iIdx_q        <= iIdx_d;
      jIdx_q        <= jIdx_d;
      errOverflow_q <= errOverflow_d;
      errTooFew_q   <= errTooFew_d;
    end
  end

  // Two identical copies give point[i] and point[j] in the same cycle.
  always_ff @(posedge clk) begin
    if (ptStore) memA[nPoints_q[ADDR_W-1:0]] <= ptIn;
    if (en)      rdA_q <= memA[iIdx_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (ptStore) memB[nPoints_q[ADDR_W-1:0]] <= ptIn;
    if (en)      rdB_q <= memB[jIdx_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      last3_q <= 1'b0;
      ids1_q  <= '0;
      ids2_q  <= '0;
      ids3_q  <= '0;
    end else if (en) begin
      v1_q    <= issue;
      last1_q <= issue && lastPair;
      ids1_q  <= '{id1: INDEX_WIDTH'(iIdx_q), id2: INDEX_WIDTH'(jIdx_q)};
      v2_q    <= v1_q;
      last2_q <= last1_q;
      ids2_q  <= ids1_q;
      v3_q    <= v2_q;
      last3_q <= last2_q;
      ids3_q  <= ids2_q;
    end
  end

  sq_dist3 #(.DIST_WIDTH(DIST_WIDTH)) u_sq_dist3 (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .a_i    (rdA_q),
    .b_i    (rdB_q),
    .dist_o (bus.out_data)
  );

  assign bus.pt_ready     = (state_q == ST_LOAD);
  assign bus.out_valid    = v3_q;
  assign bus.out_last     = last3_q;
  assign bus.out_metadata = ids3_q;
  assign busy_o           = (state_q != ST_DONE);
  assign err_overflow_o   = errOverflow_q;
  assign err_too_few_o    = errTooFew_q;

endmodule

// File: tb/tb_pair_distance_generator.sv
// Randomized scoreboard bench for pair_distance_generator: a pair-enumeration model
// queues expected beats, and a negedge monitor pops and compares every accepted beat.
module tb_pair_distance_generator;
  import pair_distance_generator_pkg::*;

  localparam int MAXP = 8;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, errOv, errFew;

  pair_distance_generator_if #(.COORD_WIDTH(17), .DIST_WIDTH(DW)) bus ();

  pair_distance_generator #(
    .MAX_POINTS  (MAXP),
    .COORD_WIDTH (17),
    .DIST_WIDTH  (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .busy_o         (busy),
    .err_overflow_o (errOv),
    .err_too_few_o  (errFew)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned     id1;
    int unsigned     id2;
    longint unsigned data;
    bit              last;
  } exp_t;

  exp_t        expQ[$];
  exp_t        mExp;
  int          nChecks   = 0;
  int          nFail     = 0;
  int          nAccepted = 0;
  int          readyMode = 0;
  int          readyCyc  = 0;
  int unsigned px[16], py[16], pz[16];

  logic [DW-1:0] heldData;
  logic [63:0]   heldMeta;
  logic          heldLast;
  bit            stalled = 0;

  task automatic checkVal(input string name, input longint unsigned act, input longint unsigned req);
    nChecks++;
    if (act !== req) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // out_ready: 0 = always high, 1 = repeating 1,0,0,1, 2 = random
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      readyCyc++;
      case (readyMode)
        1:       bus.out_ready = (readyCyc % 4 == 0) || (readyCyc % 4 == 3);
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: stall stability and in-order scoreboard comparison of accepted beats
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        checkVal("stall_valid", 64'(bus.out_valid), 64'd1);
        checkVal("stall_data", 64'(bus.out_data), 64'(heldData));
        checkVal("stall_meta", 64'(bus.out_metadata), heldMeta);
        checkVal("stall_last", 64'(bus.out_last), 64'(heldLast));
      end
      if (bus.out_valid && bus.out_ready) begin
        stalled = 0;
        if (expQ.size() == 0) begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL unexpected_beat: got pair (%0d,%0d) data 0x%0h, expected no beat",
                   bus.out_metadata.id1, bus.out_metadata.id2, bus.out_data);
        end else begin
          mExp = expQ.pop_front();
          checkVal("pair_id1", 64'(bus.out_metadata.id1), 64'(mExp.id1));
          checkVal("pair_id2", 64'(bus.out_metadata.id2), 64'(mExp.id2));
          checkVal("pair_data", 64'(bus.out_data), mExp.data);
          checkVal("pair_last", 64'(bus.out_last), 64'(mExp.last));
          nAccepted++;
        end
      end else if (bus.out_valid) begin
        stalled  = 1;
        heldData = bus.out_data;
        heldMeta = bus.out_metadata;
        heldLast = bus.out_last;
      end else begin
        stalled = 0;
      end
    end
  end

  function automatic longint unsigned absd(input int unsigned a, input int unsigned b);
    return (a > b) ? longint'(a - b) : longint'(b - a);
  endfunction

  // Reference: all pairs of the first min(n, MAXP) points, row-major, saturated to DW bits
  task automatic pushExpected(input int n);
    int nEff;
    exp_t e;
    longint unsigned d;
    nEff = (n > MAXP) ? MAXP : n;
    for (int i = 0; i < nEff; i++) begin
      for (int j = i + 1; j < nEff; j++) begin
        d = absd(px[i], px[j]) * absd(px[i], px[j])
          + absd(py[i], py[j]) * absd(py[i], py[j])
          + absd(pz[i], pz[j]) * absd(pz[i], pz[j]);
        e.id1  = i;
        e.id2  = j;
        e.data = (d > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : d;
        e.last = (i == nEff - 2) && (j == nEff - 1);
        expQ.push_back(e);
      end
    end
  endtask

  task automatic setPt(input int k, input int unsigned x, input int unsigned y, input int unsigned z);
    px[k] = x;
    py[k] = y;
    pz[k] = z;
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.pt_valid = 1'b0;
    bus.pt_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expQ.delete();
    checkVal("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("reset_pt_ready", 64'(bus.pt_ready), 64'd1);
    checkVal("reset_err_overflow", 64'(errOv), 64'd0);
    checkVal("reset_err_too_few", 64'(errFew), 64'd0);
    checkVal("reset_out_data", 64'(bus.out_data), 64'd0);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input bit gaps);
    pushExpected(n);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.pt_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      bus.pt_valid = 1'b1;
      bus.pt_x     = 17'(px[k]);
      bus.pt_y     = 17'(py[k]);
      bus.pt_z     = 17'(pz[k]);
      bus.pt_last  = (k == n - 1);
      @(posedge clk); #1;
    end
    bus.pt_valid = 1'b0;
    bus.pt_last  = 1'b0;
  endtask

  task automatic checkOutput(input int n, input int bound);
    int cyc;
    int nEff;
    cyc  = 0;
    nEff = (n > MAXP) ? MAXP : n;
    while (busy && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkVal("done_in_time", 64'(busy), 64'd0);
    @(negedge clk);
    checkVal("queue_empty", 64'(expQ.size()), 64'd0);
    checkVal("err_overflow", 64'(errOv), 64'(n > MAXP));
    checkVal("err_too_few", 64'(errFew), 64'(nEff < 2));
    checkVal("done_pt_ready", 64'(bus.pt_ready), 64'd0);
    checkVal("done_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic loadBasic();
    setPt(0, 0, 0, 0);
    setPt(1, 1, 2, 2);
    setPt(2, 3, 0, 4);
  endtask

  initial begin
    int n, base, cyc;
    bus.pt_valid = 1'b0;
    bus.pt_last  = 1'b0;
    bus.pt_x = '0;
    bus.pt_y = '0;
    bus.pt_z = '0;

    // Basic three points, with first-beat latency check
    doReset();
    loadBasic();
    applyStimulus(3, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkVal("latency_before", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    checkVal("latency_third", 64'(bus.out_valid), 64'd1);
    checkOutput(3, 50);

    // Same set under the 1,0,0,1 out_ready pattern
    readyMode = 1;
    doReset();
    loadBasic();
    applyStimulus(3, 0);
    checkOutput(3, 100);
    readyMode = 0;

    // Single point: too few, DONE within two cycles
    doReset();
    setPt(0, 5, 6, 7);
    applyStimulus(1, 0);
    checkOutput(1, 2);

    // Overflow: offer MAXP+2 points
    doReset();
    for (int k = 0; k < MAXP + 2; k++) setPt(k, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
    applyStimulus(MAXP + 2, 0);
    checkOutput(MAXP + 2, 200);

    // Saturation boundaries with a 32-bit distance
    doReset();
    setPt(0, 131071, 0, 0);
    setPt(1, 0, 0, 0);
    setPt(2, 65535, 0, 0);
    applyStimulus(3, 0);
    checkOutput(3, 50);

    // Reset during GEN after two pairs, then a fresh load
    doReset();
    for (int k = 0; k < 5; k++) setPt(k, k * 3, 7 - k, k * k);
    base = nAccepted;
    applyStimulus(5, 0);
    cyc = 0;
    while (nAccepted < base + 2 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    checkVal("pairs_before_reset", 64'(nAccepted >= base + 2), 64'd1);
    #1;
    rst = 1'b1;
    expQ.delete();
    @(posedge clk);
    @(negedge clk);
    checkVal("midrun_reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkVal("midrun_reset_pt_ready", 64'(bus.pt_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    loadBasic();
    applyStimulus(3, 0);
    checkOutput(3, 50);

    // Randomized sets, sizes, coordinates and back-pressure
    for (int r = 0; r < 9; r++) begin
      readyMode = r % 3;
      n = $urandom_range(1, MAXP + 3);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) == 1)
          setPt(k, $urandom_range(0, 131071), $urandom_range(0, 131071), $urandom_range(0, 131071));
        else
          setPt(k, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      end
      doReset();
      applyStimulus(n, 1);
      checkOutput(n, 2000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
